ram_controller: RTL and testbench
=================================

# ram_controller

Initiator side of the single-port block RAM interface: it turns CPU-side load/store requests into RAM_ENABLE/RAM_WRITE/RAM_ADDR/RAM_DATA_IN cycles and returns read data from RAM_DATA_OUT. It sits between the datapath's memory stage and the 4K x 16 RAM. It accepts one request per cycle and supports optional auto-incrementing read bursts. The RAM has a one-cycle registered read, which the controller tracks so that every read yields exactly one response.

## Interface
- ADDR_BITS, 12, RAM address width
- DATA_WIDTH, 16, RAM word width
- LEN_BITS, 4, burst length field width; burst = REQ_LEN+1 words
- CLK  in  1  sole clock, rising edge
- RESET_N  in  1  synchronous, active-low reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  controller can accept this cycle
- REQ_WRITE  in  1  1 = store, 0 = load
- REQ_ADDR  in  ADDR_BITS  start address
- REQ_WDATA  in  DATA_WIDTH  store data
- REQ_LEN  in  LEN_BITS  read burst length minus one (loads only)
- RSP_VALID  out  1  RSP_DATA valid this cycle; no backpressure
- RSP_DATA  out  DATA_WIDTH  read data (wired from RAM_DATA_OUT)
- RSP_LAST  out  1  final word of a load or burst
- WR_DONE  out  1  one-cycle pulse when a store has been issued to RAM
- RAM_ENABLE  out  1  to RAM
- RAM_WRITE  out  1  to RAM
- RAM_ADDR  out  ADDR_BITS  to RAM
- RAM_DATA_IN  out  DATA_WIDTH  to RAM
- RAM_DATA_OUT  in  DATA_WIDTH  from RAM (registered, 1-cycle read)

## Operation
- States: IDLE, BURST. REQ_READY = 1 only in IDLE (and not in reset).
- Handshake: a request is accepted at the edge where REQ_VALID & REQ_READY. Request fields are sampled only at that edge.
- Store accepted in IDLE: at the next edge drive RAM_ENABLE=1, RAM_WRITE=1, RAM_ADDR, RAM_DATA_IN for exactly one cycle. WR_DONE pulses in that same cycle. No RSP_VALID is produced. Stay in IDLE.
- Load with REQ_LEN=0: one read cycle (RAM_ENABLE=1, RAM_WRITE=0). Produces one response with RSP_LAST=1. Stay in IDLE.
- Load with REQ_LEN=L>0: first read is issued as above, then go to BURST.
  - BURST issues one read per cycle at addr+1, addr+2, … for L further cycles, with REQ_READY=0.
  - Return to IDLE on the edge that issues the last read.
- Address arithmetic is ADDR_BITS wide, modulo 2^ADDR_BITS: 0xFFF+1 = 0x000.
- Burst counter counts down from L. RSP_LAST is tagged on the issue whose count is 0 and is delayed alongside RSP_VALID.
- Back-to-back requests in IDLE (load, store, load…) issue on consecutive cycles with no bubble.
- A store issued directly after a load to the same address does not disturb the load's response; RAM read data is captured before the write lands.
- When RAM_ENABLE=0: RAM_WRITE=0. RAM_ADDR and RAM_DATA_IN hold their last values.
- Reset (RESET_N low at an edge), including mid-burst:
  - State returns to IDLE.
  - RAM_ENABLE, RAM_WRITE, RSP_VALID, RSP_LAST, WR_DONE, RAM_ADDR and RAM_DATA_IN all become 0.
  - REQ_READY is 0 while RESET_N is low.
  - Any read already issued does not produce a response.

## Timing
- All RAM-side outputs are registered.
- RSP_VALID and RSP_LAST are registered one cycle after the corresponding RAM_ENABLE cycle.
- Load accepted at edge E0: RAM_ENABLE high in cycle E0→E1, and RSP_VALID/RSP_DATA valid in cycle E1→E2. Latency is 2 edges from acceptance.
- A burst of L+1 words gives RSP_VALID high for L+1 consecutive cycles. REQ_READY returns high in the cycle after the last issue, so the next request can be accepted while the final response is still pending.
- Store: WR_DONE is high in cycle E0→E1.

## Configuration
- RAM_CTRL_BURST_EN defined: burst behaviour as specified above.
- RAM_CTRL_BURST_EN undefined:
  - REQ_LEN port is kept but ignored (treated as 0).
  - BURST state and the counter are not built.
  - Every load is a single word with RSP_LAST=1.

## Structure
- Shared package ram_ctrl_pkg holds:
  - the state enum (IDLE, BURST)
  - default constants RAM_ADDR_BITS=12, RAM_DATA_WIDTH=16, RAM_LEN_BITS=4
- No sub-module: the FSM, address incrementer and response pipeline register are small enough to live in ram_controller.

## Test plan
- Store 0x1234 at 0x010, then load 0x010 → WR_DONE one cycle; RSP_VALID 2 edges after load acceptance with RSP_DATA=0x1234, RSP_LAST=1.
- Burst load addr 0x020, REQ_LEN=3, preloaded 0xA0..0xA3 → four consecutive RSP_VALID cycles returning 0xA0,0xA1,0xA2,0xA3; RSP_LAST only on 0xA3; REQ_READY low for 3 cycles.
- Burst at 0xFFE, REQ_LEN=2 → RAM_ADDR sequence 0xFFE, 0xFFF, 0x000; data returned in that order.
- Alternating load 0x005 / store 0x005←0xBEEF / load 0x005 on consecutive cycles, old value 0x0001 → responses 0x0001 then 0xBEEF; no bubbles.
- RESET_N low for one edge on the second burst cycle (REQ_LEN=7) → no further RAM_ENABLE; RSP_VALID 0 from the reset edge; REQ_READY=1 the cycle after release.
- Build without RAM_CTRL_BURST_EN, load with REQ_LEN=5 → exactly one response, RSP_LAST=1, REQ_READY never drops.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// ============================================================================
// Module   : ram_ctrl_pkg
// Brief    : Shared state encoding and default geometry for ram_controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ram_ctrl_pkg;

  localparam int RAM_ADDR_BITS  = 12;
  localparam int RAM_DATA_WIDTH = 16;
  localparam int RAM_LEN_BITS   = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/ram_controller.sv
// ============================================================================
// Module   : ram_controller
// Brief    : Load/store initiator for a single-port RAM with registered read.
//            Build option RAM_CTRL_BURST_EN enables auto-increment read bursts.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_controller
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_BITS  = RAM_ADDR_BITS,
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int LEN_BITS   = RAM_LEN_BITS
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_BITS-1:0]  REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  input  logic [LEN_BITS-1:0]   REQ_LEN,
  output logic                  RSP_VALID,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP_LAST,
  output logic                  WR_DONE,
  output logic                  RAM_ENABLE,
  output logic                  RAM_WRITE,
  output logic [ADDR_BITS-1:0]  RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_DATA_IN,
  input  logic [DATA_WIDTH-1:0] RAM_DATA_OUT
);

  logic                  en_q, en_d;
  logic                  we_q, we_d;
  logic                  last_q, last_d;
  logic                  wr_done_q, wr_done_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_last_q, rsp_last_d;
  logic                  w_accept;

`ifdef RAM_CTRL_BURST_EN
  state_e               state_q, state_d;
  logic [LEN_BITS-1:0]  cnt_q, cnt_d;

  assign REQ_READY = RESET_N && (state_q == IDLE);
`else
  logic unused_req_len;

  assign unused_req_len = ^REQ_LEN;
  assign REQ_READY      = RESET_N;
`endif

  assign w_accept = REQ_VALID && REQ_READY;

  always_comb begin
    en_d      = 1'b0;
    we_d      = 1'b0;
    last_d    = 1'b0;
    wr_done_d = 1'b0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
`ifdef RAM_CTRL_BURST_EN
    state_d   = state_q;
    cnt_d     = cnt_q;
`endif

    if (w_accept) begin
      en_d   = 1'b1;
      we_d   = REQ_WRITE;
      addr_d = REQ_ADDR;
      if (REQ_WRITE) begin
        wdata_d   = REQ_WDATA;
        wr_done_d = 1'b1;
      end else begin
`ifdef RAM_CTRL_BURST_EN
        // cnt tracks the issue count of the read currently on the RAM port
        cnt_d  = REQ_LEN;
        last_d = (REQ_LEN == '0);
        if (REQ_LEN != '0) begin
          state_d = BURST;
        end
`else
        last_d = 1'b1;
`endif
      end
    end

`ifdef RAM_CTRL_BURST_EN
    if (state_q == BURST) begin
      en_d   = 1'b1;
      addr_d = addr_q + ADDR_BITS'(1);
      cnt_d  = cnt_q - LEN_BITS'(1);
      last_d = (cnt_d == '0);
      if (cnt_d == '0) begin
        state_d = IDLE;
      end
    end
`endif
  end

  // Response strobes trail the read issue by one cycle to match the RAM latency
  assign rsp_valid_d = en_q && !we_q;
  assign rsp_last_d  = en_q && !we_q && last_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      en_q        <= 1'b0;
      we_q        <= 1'b0;
      last_q      <= 1'b0;
      wr_done_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      en_q        <= en_d;
      we_q        <= we_d;
      last_q      <= last_d;
      wr_done_q   <= wr_done_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_last_q  <= rsp_last_d;
    end
  end

`ifdef RAM_CTRL_BURST_EN
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign RAM_ENABLE  = en_q;
  assign RAM_WRITE   = we_q;
  assign RAM_ADDR    = addr_q;
  assign RAM_DATA_IN = wdata_q;
  assign WR_DONE     = wr_done_q;
  assign RSP_VALID   = rsp_valid_q;
  assign RSP_LAST    = rsp_last_q;
  assign RSP_DATA    = RAM_DATA_OUT;

endmodule

`default_nettype wire

// File: tb/tb_ram_controller.sv
// ============================================================================
// Module   : tb_ram_controller
// Brief    : Scoreboard bench for ram_controller with a behavioural RAM and
//            reference model; honours RAM_CTRL_BURST_EN like the design.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_controller;

  localparam int AW = 12;
  localparam int DW = 16;
  localparam int LW = 4;
  localparam int DEPTH = 1 << AW;
`ifdef RAM_CTRL_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          REQ_VALID = 1'b0;
  logic          REQ_WRITE = 1'b0;
  logic [AW-1:0] REQ_ADDR = '0;
  logic [DW-1:0] REQ_WDATA = '0;
  logic [LW-1:0] REQ_LEN = '0;
  logic          REQ_READY;
  logic          RSP_VALID;
  logic [DW-1:0] RSP_DATA;
  logic          RSP_LAST;
  logic          WR_DONE;
  logic          RAM_ENABLE;
  logic          RAM_WRITE;
  logic [AW-1:0] RAM_ADDR;
  logic [DW-1:0] RAM_DATA_IN;
  logic [DW-1:0] RAM_DATA_OUT = '0;

  ram_controller #(.ADDR_BITS(AW), .DATA_WIDTH(DW), .LEN_BITS(LW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA), .REQ_LEN(REQ_LEN),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_LAST(RSP_LAST),
    .WR_DONE(WR_DONE), .RAM_ENABLE(RAM_ENABLE), .RAM_WRITE(RAM_WRITE),
    .RAM_ADDR(RAM_ADDR), .RAM_DATA_IN(RAM_DATA_IN), .RAM_DATA_OUT(RAM_DATA_OUT)
  );

  always #5 CLK = ~CLK;

  function automatic logic [DW-1:0] init_val(input int i);
    return DW'(i * 40503 + 17);
  endfunction

  // Behavioural read-first RAM with registered output
  logic [DW-1:0] ram [DEPTH];
  bit            ram_init = 1'b0;
  always @(posedge CLK) begin
    if (!ram_init) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else if (RAM_ENABLE) begin
      if (RAM_WRITE) ram[RAM_ADDR] <= RAM_DATA_IN;
      else           RAM_DATA_OUT  <= ram[RAM_ADDR];
    end
  end

  typedef struct packed { logic w; logic [AW-1:0] a; logic [DW-1:0] d; } issue_t;
  typedef struct packed { logic [DW-1:0] d; logic last; } rsp_t;

  issue_t        iss_q[$];
  rsp_t          rsp_q[$];
  logic [DW-1:0] shadow [DEPTH];
  int            busy = 0;
  int            n_chk = 0;
  int            n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // Monitor: compares RAM-side issues and responses against the queues
  issue_t        m_iss;
  rsp_t          m_rsp;
  logic          prev_rd = 1'b0;
  logic [AW-1:0] hold_a = '0;
  logic [DW-1:0] hold_d = '0;
  always @(posedge CLK) begin
    #1;
    if (!RESET_N) begin
      chk("rst_enable", 32'(RAM_ENABLE), 0);
      chk("rst_write", 32'(RAM_WRITE), 0);
      chk("rst_addr", 32'(RAM_ADDR), 0);
      chk("rst_din", 32'(RAM_DATA_IN), 0);
      chk("rst_rsp_valid", 32'(RSP_VALID), 0);
      chk("rst_rsp_last", 32'(RSP_LAST), 0);
      chk("rst_wr_done", 32'(WR_DONE), 0);
      chk("rst_ready", 32'(REQ_READY), 0);
      prev_rd = 1'b0;
      hold_a  = '0;
      hold_d  = '0;
    end else begin
      chk("rsp_timing", 32'(RSP_VALID), 32'(prev_rd));
      if (RSP_VALID) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          m_rsp = rsp_q.pop_front();
          chk("rsp_data", 32'(RSP_DATA), 32'(m_rsp.d));
          chk("rsp_last", 32'(RSP_LAST), 32'(m_rsp.last));
        end
      end
      prev_rd = 1'b0;
      if (RAM_ENABLE) begin
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          m_iss = iss_q.pop_front();
          chk("issue_write", 32'(RAM_WRITE), 32'(m_iss.w));
          chk("issue_addr", 32'(RAM_ADDR), 32'(m_iss.a));
          chk("issue_wr_done", 32'(WR_DONE), 32'(m_iss.w));
          chk("issue_din", 32'(RAM_DATA_IN), m_iss.w ? 32'(m_iss.d) : 32'(hold_d));
          hold_a  = m_iss.a;
          if (m_iss.w) hold_d = m_iss.d;
          prev_rd = !m_iss.w;
        end
      end else begin
        chk("issue_bubble", 32'(iss_q.size()), 0);
        chk("idle_write", 32'(RAM_WRITE), 0);
        chk("idle_wr_done", 32'(WR_DONE), 0);
        chk("idle_addr_hold", 32'(RAM_ADDR), 32'(hold_a));
        chk("idle_din_hold", 32'(RAM_DATA_IN), 32'(hold_d));
      end
    end
  end

  // Driver plus reference model: expectations are queued at acceptance
  task automatic drive(input bit v, input bit w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [LW-1:0] l);
    int            n;
    logic [AW-1:0] aa;
    @(negedge CLK);
    RESET_N   = 1'b1;
    REQ_VALID = v;
    REQ_WRITE = w;
    REQ_ADDR  = a;
    REQ_WDATA = d;
    REQ_LEN   = l;
    #1;
    chk("req_ready", 32'(REQ_READY), 32'(busy == 0));
    if (v && busy == 0) begin
      if (w) begin
        shadow[a] = d;
        iss_q.push_back(issue_t'{w: 1'b1, a: a, d: d});
      end else begin
        n = BURST_EN ? int'(l) : 0;
        for (int i = 0; i <= n; i++) begin
          aa = AW'((int'(a) + i) % DEPTH);
          iss_q.push_back(issue_t'{w: 1'b0, a: aa, d: '0});
          rsp_q.push_back(rsp_t'{d: shadow[aa], last: (i == n)});
        end
        busy = n;
      end
    end else if (busy > 0) begin
      busy--;
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      RESET_N   = 1'b0;
      REQ_VALID = 1'b0;
      iss_q.delete();
      rsp_q.delete();
      busy = 0;
      #1;
      chk("ready_in_reset", 32'(REQ_READY), 0);
    end
  endtask

  initial begin
    logic [AW-1:0] ra;
    for (int i = 0; i < DEPTH; i++) shadow[i] = init_val(i);
    do_reset(3);

    // Store then load back
    drive(1, 1, 12'h010, 16'h1234, 0);
    drive(1, 0, 12'h010, 16'h0000, 0);
    idle(3);

    // Four-word burst over preloaded data
    for (int i = 0; i < 4; i++) drive(1, 1, AW'(12'h020 + i), DW'(16'h00A0 + i), 0);
    drive(1, 0, 12'h020, 16'h0000, 3);
    idle(6);

    // Burst wrapping past the top of the address space
    drive(1, 1, 12'hFFE, 16'h0FFE, 0);
    drive(1, 1, 12'hFFF, 16'h0FFF, 0);
    drive(1, 1, 12'h000, 16'h0F00, 0);
    drive(1, 0, 12'hFFE, 16'h0000, 2);
    idle(5);

    // Load / store / load to one address with no gaps
    drive(1, 1, 12'h005, 16'h0001, 0);
    drive(1, 0, 12'h005, 16'h0000, 0);
    drive(1, 1, 12'h005, 16'hBEEF, 0);
    drive(1, 0, 12'h005, 16'h0000, 0);
    idle(3);

    // Reset during the second burst cycle
    drive(1, 0, 12'h100, 16'h0000, 7);
    idle(1);
    do_reset(1);
    idle(4);

    // Long length field (single word when bursts are not built)
    drive(1, 0, 12'h200, 16'h0000, 5);
    idle(8);

    // Randomized traffic
    for (int it = 0; it < 600; it++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1);
      end else begin
        ra = ($urandom_range(0, 3) == 0) ? AW'(12'hFF0 | AW'($urandom_range(0, 15)))
                                         : AW'($urandom_range(0, 63));
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, ra,
              DW'($urandom), LW'(($urandom_range(0, 2) == 0) ? $urandom_range(0, 15) : 0));
      end
    end

    idle(24);
    chk("drain_issues", 32'(iss_q.size()), 0);
    chk("drain_responses", 32'(rsp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
